// File: rtl/min_sec_timebase_if.sv
// Control inputs and display/chime outputs of the mm:ss timebase.
// The master drives the keys and the tick. The slave is the timebase.
interface min_sec_timebase_if;
    logic       SEC_TICK;
    logic       RUN;
    logic       ADJ_MIN;
    logic       ADJ_HR;
    logic [3:0] SecH;
    logic [3:0] SecL;
    logic [3:0] MinH;
    logic [3:0] MinL;
    logic       HrEn;
    logic       BeepLo;
    logic       BeepHi;

    modport master (
        output SEC_TICK, RUN, ADJ_MIN, ADJ_HR,
        input  SecH, SecL, MinH, MinL, HrEn, BeepLo, BeepHi
    );

    modport slave (
        input  SEC_TICK, RUN, ADJ_MIN, ADJ_HR,
        output SecH, SecL, MinH, MinL, HrEn, BeepLo, BeepHi
    );
endinterface

// File: rtl/min_sec_timebase.sv
// Seconds/minutes BCD timebase (00:00-59:59) with adjust keys, a one-cycle
// hour-enable pulse for the downstream hour stage, and hourly chime strobes.
module min_sec_timebase (
    input  logic               CP,
    input  logic               nCLR,
    min_sec_timebase_if.slave  bus
);

    logic [3:0] sec_h, sec_l, min_h, min_l;
    logic [3:0] sec_h_n, sec_l_n, min_h_n, min_l_n;
    logic       hr_en, beep_lo, beep_hi;
    logic       hr_en_n, beep_lo_n, beep_hi_n;
    logic       tick, sec_bad, min_bad, sec_carry, hr_carry;

    // BCD increment of a 00-59 field given as {tens, units}.
    function automatic logic [7:0] inc60(input logic [3:0] h, input logic [3:0] l);
        if (l == 4'd9)
            return (h == 4'd5) ? 8'h00 : {h + 4'd1, 4'd0};
        else
            return {h, l + 4'd1};
    endfunction

    assign tick    = bus.SEC_TICK & bus.RUN;
    assign sec_bad = (sec_h > 4'd5) | (sec_l > 4'd9);
    assign min_bad = (min_h > 4'd5) | (min_l > 4'd9);

    always_comb begin
        sec_h_n   = sec_h;
        sec_l_n   = sec_l;
        min_h_n   = min_h;
        min_l_n   = min_l;
        sec_carry = 1'b0;
        hr_carry  = 1'b0;

        if (tick && (sec_bad || min_bad)) begin
            // Recovery clears the whole field and takes priority over the adjust key.
            sec_h_n = '0;
            sec_l_n = '0;
            min_h_n = '0;
            min_l_n = '0;
        end else begin
            if (tick) begin
                {sec_h_n, sec_l_n} = inc60(sec_h, sec_l);
                sec_carry = ({sec_h, sec_l} == 8'h59);
            end
            if (bus.ADJ_MIN) begin
                // The adjust step replaces any seconds carry in the same cycle.
                if (min_bad)
                    {min_h_n, min_l_n} = 8'h00;
                else
                    {min_h_n, min_l_n} = inc60(min_h, min_l);
            end else if (sec_carry) begin
                {min_h_n, min_l_n} = inc60(min_h, min_l);
                hr_carry = ({min_h, min_l} == 8'h59);
            end
        end
    end

    assign hr_en_n   = hr_carry | bus.ADJ_HR;
    assign beep_lo_n = ({min_h_n, min_l_n, sec_h_n} == 12'h595) &&
                       (sec_l_n inside {4'd1, 4'd3, 4'd5, 4'd7});
    assign beep_hi_n = ({min_h_n, min_l_n, sec_h_n, sec_l_n} == 16'h5959);

    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            sec_h   <= '0;
            sec_l   <= '0;
            min_h   <= '0;
            min_l   <= '0;
            hr_en   <= 1'b0;
            beep_lo <= 1'b0;
            beep_hi <= 1'b0;
        end else begin
            sec_h   <= sec_h_n;
            sec_l   <= sec_l_n;
            min_h   <= min_h_n;
            min_l   <= min_l_n;
            hr_en   <= hr_en_n;
            beep_lo <= beep_lo_n;
            beep_hi <= beep_hi_n;
        end
    end

    assign bus.SecH   = sec_h;
    assign bus.SecL   = sec_l;
    assign bus.MinH   = min_h;
    assign bus.MinL   = min_l;
    assign bus.HrEn   = hr_en;
    assign bus.BeepLo = beep_lo;
    assign bus.BeepHi = beep_hi;

endmodule

// File: tb/tb_min_sec_timebase.sv
// Directed bench for min_sec_timebase: a vector table, then multi-cycle sequences
// for roll-over, chime, adjust, simultaneous events, freeze, recovery and reset.
module tb_min_sec_timebase;

    logic       CP;
    logic       nCLR;
    logic [7:0] hr_cnt;
    int         tests;
    int         fails;

    min_sec_timebase_if bus ();

    min_sec_timebase dut (
        .CP   (CP),
        .nCLR (nCLR),
        .bus  (bus.slave)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    // Stand-in for the downstream hour counter clocked by HrEn.
    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR)
            hr_cnt <= '0;
        else if (bus.HrEn)
            hr_cnt <= hr_cnt + 8'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        tick;
        logic        run;
        logic        adj_min;
        logic        adj_hr;
        logic [15:0] mmss;
        logic        hr_en;
        logic        lo;
        logic        hi;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [15:0] mmss_now();
        return {bus.MinH, bus.MinL, bus.SecH, bus.SecL};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] mmss,
                             input logic hr, input logic lo, input logic hi);
        check(name, {13'd0, mmss_now(), bus.HrEn, bus.BeepLo, bus.BeepHi},
                    {13'd0, mmss, hr, lo, hi});
    endtask

    task automatic step(input logic tick, input logic run, input logic am, input logic ah);
        @(negedge CP);
        bus.SEC_TICK = tick;
        bus.RUN      = run;
        bus.ADJ_MIN  = am;
        bus.ADJ_HR   = ah;
        @(posedge CP);
        #1;
        bus.SEC_TICK = 1'b0;
        bus.RUN      = 1'b1;
        bus.ADJ_MIN  = 1'b0;
        bus.ADJ_HR   = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic adj_mins(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] h0;
        tests = 0;
        fails = 0;

        //            tick  run  adjm adjh  mmss      hr  lo  hi
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0203, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0204, 1'b0, 1'b0, 1'b0};

        bus.SEC_TICK = 1'b0;
        bus.RUN      = 1'b1;
        bus.ADJ_MIN  = 1'b0;
        bus.ADJ_HR   = 1'b0;
        nCLR         = 1'b0;
        repeat (3) @(posedge CP);
        #1;
        check_all("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge CP);
        nCLR = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].tick, tbl[i].run, tbl[i].adj_min, tbl[i].adj_hr);
            check_all($sformatf("vec%0d", i), tbl[i].mmss, tbl[i].hr_en, tbl[i].lo, tbl[i].hi);
        end

        // Preload 59:50, then tick through the chime window and the roll-over.
        adj_mins(57);
        ticks(46);
        check_all("preload_5950", 16'h5950, 1'b0, 1'b0, 1'b0);
        for (int unsigned k = 1; k <= 9; k++) begin
            logic [3:0] u;
            u = 4'(k);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("chime_59_5%0d", k), {12'h595, u}, 1'b0,
                      (k == 1 || k == 3 || k == 5 || k == 7), (k == 9));
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("roll_0000", 16'h0000, 1'b1, 1'b0, 1'b0);
        h0 = hr_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("roll_after", 16'h0000, 1'b0, 1'b0, 1'b0);
        check("roll_hour_inc", {24'd0, hr_cnt}, {24'd0, h0 + 8'd1});
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("roll_hour_once", {24'd0, hr_cnt}, {24'd0, h0 + 8'd1});

        // Adjust-induced minute wrap does not pulse HrEn.
        adj_mins(59);
        ticks(30);
        check_all("preload_5930", 16'h5930, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_all("adj_min_wrap", 16'h0030, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_all("adj_hr_frozen", 16'h0030, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("adj_hr_single", 16'h0030, 1'b0, 1'b0, 1'b0);

        // Tick and ADJ_MIN together at 12:59 advance minutes once only.
        adj_mins(12);
        ticks(29);
        check_all("preload_1259", 16'h1259, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_all("tick_adjmin", 16'h1300, 1'b0, 1'b0, 1'b0);

        // Tick and ADJ_HR together at 59:59 give one hour step.
        adj_mins(46);
        ticks(59);
        check_all("preload_5959", 16'h5959, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_all("tick_adjhr", 16'h0000, 1'b1, 1'b0, 1'b0);
        h0 = hr_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("tick_adjhr_after", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("tick_adjhr_hour", {24'd0, hr_cnt}, {24'd0, h0 + 8'd1});

        // Frozen ticks are dropped.
        adj_mins(3);
        ticks(7);
        for (int unsigned i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("freeze", 16'h0307, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_all("unfreeze", 16'h0308, 1'b0, 1'b0, 1'b0);

        // Illegal units digit recovers to 00:00 on the next tick.
        @(negedge CP);
        force dut.sec_l = 4'd12;
        #1;
        release dut.sec_l;
        #1;
        check("illegal_loaded", {28'd0, bus.SecL}, 32'd12);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("illegal_recover", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while HrEn is high.
        adj_mins(37);
        ticks(42);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_all("pre_reset", 16'h3742, 1'b1, 1'b0, 1'b0);
        #2;
        nCLR = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge CP);
        nCLR = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("post_reset_tick", 16'h0001, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/min_sec_timebase.md
# min_sec_timebase

Seconds/minutes BCD timebase for the digital clock, sitting directly upstream of the 24-hour counter stage. It counts a 1 Hz tick into 00:00–59:59 and handles minute and hour adjustment keys. It emits a one-cycle hour-enable pulse that drives the hour counter's EN input on the same CP clock. It also generates the hourly chime strobes (low tone at xx:59:51/53/55/57, high tone at xx:59:59).

## Interface
- No parameters; BCD limits are fixed (seconds and minutes 0–59).
- CP  input  1  system clock; all state updates on the rising edge.
- nCLR  input  1  reset, asynchronous, active-low.
- SEC_TICK  input  1  one-CP-cycle pulse, nominally 1 Hz, synchronous to CP.
- RUN  input  1  level; 0 freezes time counting (adjust keys still act).
- ADJ_MIN  input  1  one-cycle pulse (already debounced); increments minutes by one.
- ADJ_HR  input  1  one-cycle pulse (already debounced); requests one hour increment.
- SecH  output  4  seconds tens digit, 0–5.
- SecL  output  4  seconds units digit, 0–9.
- MinH  output  4  minutes tens digit, 0–5.
- MinL  output  4  minutes units digit, 0–9.
- HrEn  output  1  registered one-cycle pulse; hour stage enable.
- BeepLo  output  1  registered; low-tone chime active.
- BeepHi  output  1  registered; high-tone chime active.

## Operation
- Reset (nCLR=0, asynchronous): all digits 0, HrEn=0, BeepLo=0, BeepHi=0. The block holds this state while nCLR=0. Release takes effect on the next CP edge.
- Count event: SEC_TICK=1 and RUN=1 at the CP edge. Seconds count BCD 00→59→00.
  - The seconds wrap 59→00 carries one into minutes.
  - A minutes wrap 59→00 caused by that carry sets HrEn for exactly one cycle.
- ADJ_MIN=1: minutes advance by exactly one, BCD, 59→00. An adjust-induced minute wrap never sets HrEn. Seconds are unaffected by the adjust.
- ADJ_MIN together with a count event in the same cycle:
  - Seconds advance normally.
  - Minutes advance by exactly one; the seconds carry is discarded for that cycle.
  - HrEn is not set by the count event.
- ADJ_HR=1: HrEn=1 next cycle, independent of RUN, SEC_TICK and the digits. If ADJ_HR coincides with a count-generated hour carry, HrEn is still a single one-cycle pulse, so the hour advances by one only.
- HrEn is 0 in every cycle not specified above.
- Illegal-value recovery: on any count event, if any digit is out of range (SecH>5, SecL>9, MinH>5, MinL>9), the whole mm:ss field loads 00:00 and HrEn is not set. The same applies to ADJ_MIN: an illegal minutes field loads 00.
- RUN=0: a SEC_TICK is ignored and is not queued.
- Chime:
  - BeepLo=1 while the registered time is MM=59 with SS ∈ {51,53,55,57}.
  - BeepHi=1 while the registered time is 59:59.
  - Both are 0 otherwise and are never 1 simultaneously.

## Timing
- Digits update on the CP edge that samples SEC_TICK/ADJ_MIN high; they are visible the same cycle after that edge.
- BeepLo/BeepHi are computed from the next-state digits and registered on the same edge, so they are cycle-aligned with the displayed digits. They carry no combinational path from any input.
- HrEn is high for the one cycle following the edge where 59:59→00:00 (or the edge sampling ADJ_HR). The hour stage therefore increments on the edge after that, i.e. the hour display lags mm:ss by one CP cycle.
- Back-to-back SEC_TICK in consecutive cycles must count every tick; no throughput limit.
- Reset asserted mid-operation (including the cycle HrEn=1) clears HrEn immediately; no pending hour pulse survives reset.

## Test plan
- Reset: drive nCLR=0 asynchronously mid-cycle from 37:42 → all digits 0, HrEn=BeepLo=BeepHi=0 without waiting for a CP edge.
- Full roll: preload 59:58 via ADJ_MIN/ticks, then apply two ticks:
  - after the first tick → 59:59 with BeepHi=1;
  - after the second → 00:00 with HrEn=1 for exactly one cycle, and an attached hour counter advances by one on the following edge.
- Chime sequence: run ticks from 59:50 to 00:00 → BeepLo high only at :51/:53/:55/:57 and BeepHi only at :59.
- Adjust: at 59:30 pulse ADJ_MIN → 00:30, HrEn stays 0. Pulse ADJ_HR with RUN=0 → single HrEn pulse, digits unchanged.
- Simultaneous events:
  - At 12:59, tick and ADJ_MIN in the same cycle → 13:00, not 14:00.
  - At 59:59, tick and ADJ_HR together → one HrEn pulse only.
- Freeze and recovery:
  - RUN=0 with 10 ticks → time unchanged.
  - Force an illegal digit (e.g. SecL=12), then apply one tick → 00:00 with no HrEn.
